// File: rtl/dahb_master_bridge.sv
// DAHB responder: queues core loads/stores in an in-order buffer and replays
// each one as a single, non-overlapped AHB-Lite transfer.
module dahb_master_bridge #(
  parameter int BUF_DEPTH  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  DAHB_access,
  input  logic                  DAHB_rd0_wr1,
  input  logic [3:0]            DAHB_byte_strobe,
  input  logic [DATA_WIDTH-1:0] DAHB_write_data,
  input  logic [ADDR_WIDTH-1:0] DAHB_addr,
  output logic                  DAHB_trans_buffer_full,
  output logic [DATA_WIDTH-1:0] DAHB_read_data,
  output logic                  DAHB_read_data_valid,
  output logic                  DAHB_bus_error,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  logic                  buf_rw    [BUF_DEPTH];
  logic [3:0]            buf_strb  [BUF_DEPTH];
  logic [ADDR_WIDTH-3:0] buf_addr  [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_wdata [BUF_DEPTH];

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  state_t                state;
  logic                  cmd_bad;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  push, pop;
  logic [2:0]            dec_size;
  logic [1:0]            dec_lo;
  logic                  dec_bad;
  logic                  unused_addr_lo;

  assign push           = DAHB_access && !DAHB_trans_buffer_full;
  assign pop            = (state == ST_IDLE) && (count != '0);
  assign HBURST         = 3'b000;
  assign HPROT          = 4'b0011;
  // The low address bits are regenerated from the strobe lane decode.
  assign unused_addr_lo = ^DAHB_addr[1:0];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  always_comb begin
    dec_size = 3'b010;
    dec_lo   = 2'b00;
    dec_bad  = 1'b0;
    case (buf_strb[rd_ptr])
      4'b0001: begin dec_size = 3'b000; dec_lo = 2'b00; end
      4'b0010: begin dec_size = 3'b000; dec_lo = 2'b01; end
      4'b0100: begin dec_size = 3'b000; dec_lo = 2'b10; end
      4'b1000: begin dec_size = 3'b000; dec_lo = 2'b11; end
      4'b0011: begin dec_size = 3'b001; dec_lo = 2'b00; end
      4'b1100: begin dec_size = 3'b001; dec_lo = 2'b10; end
      4'b1111: begin dec_size = 3'b010; dec_lo = 2'b00; end
      default: dec_bad = 1'b1;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (push) begin
      buf_rw[wr_ptr]    <= DAHB_rd0_wr1;
      buf_strb[wr_ptr]  <= DAHB_byte_strobe;
      buf_addr[wr_ptr]  <= DAHB_addr[ADDR_WIDTH-1:2];
      buf_wdata[wr_ptr] <= DAHB_write_data;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      count                  <= '0;
      DAHB_trans_buffer_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count                  <= count_next;
      DAHB_trans_buffer_full <= (count_next == FULL_CNT);
    end
  end

  // Address and data phases never overlap, so a single command register suffices.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state                <= ST_IDLE;
      HTRANS               <= 2'b00;
      HADDR                <= '0;
      HWRITE               <= 1'b0;
      HSIZE                <= 3'b010;
      HWDATA               <= '0;
      cmd_bad              <= 1'b0;
      cmd_wdata            <= '0;
      DAHB_read_data       <= '0;
      DAHB_read_data_valid <= 1'b0;
      DAHB_bus_error       <= 1'b0;
    end else begin
      DAHB_read_data_valid <= 1'b0;
      DAHB_bus_error       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            HADDR     <= {buf_addr[rd_ptr], dec_lo};
            HWRITE    <= buf_rw[rd_ptr];
            HSIZE     <= dec_size;
            HTRANS    <= 2'b10;
            cmd_bad   <= dec_bad;
            cmd_wdata <= buf_wdata[rd_ptr];
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            HTRANS <= 2'b00;
            HWDATA <= cmd_wdata;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            state          <= ST_IDLE;
            DAHB_bus_error <= HRESP || cmd_bad;
            if (!HWRITE) begin
              DAHB_read_data       <= HRESP ? '0 : HRDATA;
              DAHB_read_data_valid <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
